conv77_ctrl: RTL and testbench
==============================

Name: conv77_ctrl

Overview:
- Sequencing controller for the 7x7 convolution engine (7 row inputs, 49-tap filter, single-cycle multiply-accumulate (MAC), shift on `en`).
- Accepts a frame as a stream of 7-pixel columns, one row-band at a time, and drives the engine's `en`.
- Suppresses the 6 warm-up columns of each band and captures valid engine results into a one-entry output register.
- Output register has a valid/ready handshake and carries output coordinates.

Parameters:
- IMG_W, 32, image width in columns; legal range 7..255.
- IMG_H, 32, image height in rows; legal range 7..255. Number of bands = IMG_H-6.
- OUT_WIDTH, 8, width of the engine result and of out_data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from frame start until the done pulse.
- done  out  1  one-cycle pulse when the last output of a frame has been consumed.
- in_valid  in  1  upstream column-pixel data presented.
- in_ready  out  1  controller can accept a column this cycle.
- conv_en  out  1  to engine `en`; equals in_valid && in_ready.
- conv_value  in  OUT_WIDTH  engine convValue (combinational from the engine window).
- out_valid  out  1  out_data/out_row/out_col hold a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_WIDTH  captured result.
- out_row  out  8  band index of the result (0..IMG_H-7).
- out_col  out  8  column index of the result (0..IMG_W-7).

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; col_cnt, band_cnt, win_pend, busy, done, out_valid, in_ready = 0; out_data, out_row, out_col = 0. Reset mid-frame abandons the frame and discards any pending result.
- State machine: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start=1. Clear col_cnt and band_cnt; busy=1.
  - RUN -> DRAIN on accepting column IMG_W-1 of band IMG_H-7.
  - DRAIN -> IDLE when win_pend=0 and out_valid=0. done=1 for exactly that one cycle; busy=0 in the same cycle.
- start is ignored in RUN and DRAIN.
- in_ready = (state==RUN) && !(win_pend && out_valid && !out_ready). Column accept = in_valid && in_ready.
- Counters on each accept:
  - col_cnt increments; it wraps IMG_W-1 -> 0, and on the wrap band_cnt increments.
  - The engine window is not flushed at a band boundary; the stale columns are masked because col_cnt restarts.
- Window tracking:
  - An accept with col_cnt>=6 sets win_pend.
  - The same accept latches tag_row=band_cnt and tag_col=col_cnt-6.
- Capture:
  - Capture occurs when win_pend && (!out_valid || out_ready).
  - On capture: out_data <= conv_value (post-processed, see the optional feature); out_row/out_col <= tags; out_valid <= 1.
  - win_pend clears on capture unless the same cycle's accept sets it again (set wins).
- Latency: a window-completing column accepted at edge E gives out_valid=1 after edge E+1, with no backpressure.
- Output handshake:
  - out_valid && out_ready with no simultaneous capture -> out_valid <= 0.
  - Simultaneous drain and capture -> out_valid stays 1 and the new data loads.
  - out_data, out_row and out_col are stable while out_valid && !out_ready.
- Backpressure: while win_pend is held, conv_en=0, so the engine window and conv_value stay frozen; no result is lost or duplicated.
- Totals per frame: IMG_W*(IMG_H-6) accepts and (IMG_W-6)*(IMG_H-6) outputs, in raster order (band, then column).
- Arithmetic: no widening. conv_value passes unchanged except as modified by the optional feature.

Optional Feature:
- Macro: CONV77_CTRL_RELU_EN.
- Defined: on capture, a negative conv_value (MSB=1) is stored as 0; non-negative values pass unchanged.
- Undefined: conv_value is stored bit-exact. No other behaviour changes.

Test Plan:
- Reset, then IMG_W=8, IMG_H=8, start, in_valid held 1, out_ready held 1:
  - 16 accepts in 16 cycles.
  - out_valid first high 2 cycles after the 7th accept.
  - 4 outputs tagged (0,0),(0,1),(1,0),(1,1).
  - done pulses once after the 4th output is consumed; busy then 0.
- Band wrap, same config: accepts 9..14 (the second band's columns 0..5) produce no output; the 15th accept yields tag (1,0).
- Backpressure: hold out_ready=0 for 5 cycles after the first out_valid.
  - in_ready drops once win_pend is set; conv_en stays 0.
  - out_data is stable; after release, all 4 results arrive with no loss or duplicate.
- Throttled input: in_valid toggles every other cycle; counters advance only on accepts; output tags and count are unchanged from the first scenario.
- start pulsed during RUN is ignored. rst=0 mid-band forces IDLE, all outputs 0, and the pending result is dropped. A fresh start then replays the full 4-output frame.
- With CONV77_CTRL_RELU_EN defined, force conv_value=8'hF0 at capture -> out_data=0. Without it -> out_data=8'hF0. conv_value=8'h12 -> 8'h12 in both builds.

Source files
------------

// File: rtl/conv77_ctrl.sv
// conv77_ctrl: sequencing controller for a 7x7 convolution engine.
// Streams 7-pixel columns one row-band at a time, drives the engine shift
// enable, hides the 6 warm-up columns of each band and captures valid
// results into a one-entry output register with a valid/ready handshake.
// Optional build macro: CONV77_CTRL_RELU_EN (clamp negative results to 0).
module conv77_ctrl #(
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 conv_en,
  input  logic [OUT_WIDTH-1:0] conv_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [7:0]           out_row,
  output logic [7:0]           out_col
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [7:0]           col_cnt;
  logic [7:0]           band_cnt;
  logic [7:0]           tag_row;
  logic [7:0]           tag_col;
  logic                 win_pend;
  logic                 accept;
  logic                 capture;
  logic                 last_col;
  logic                 last_band;
  logic [OUT_WIDTH-1:0] cap_data;

  // A completed window waiting on a full, stalled output register blocks
  // new columns so the engine window (and conv_value) stays frozen.
  assign in_ready  = (state == RUN) && !(win_pend && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign conv_en   = accept;
  assign capture   = win_pend && (!out_valid || out_ready);
  assign last_col  = (col_cnt == 8'(IMG_W - 1));
  assign last_band = (band_cnt == 8'(IMG_H - 7));

`ifdef CONV77_CTRL_RELU_EN
  assign cap_data = conv_value[OUT_WIDTH-1] ? '0 : conv_value;
`else
  assign cap_data = conv_value;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_col && last_band) state_nxt = DRAIN;
      DRAIN:   if (!win_pend && !out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame status and column/band counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      col_cnt  <= '0;
      band_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        busy     <= 1'b1;
        col_cnt  <= '0;
        band_cnt <= '0;
      end
      if (state == DRAIN && state_nxt == IDLE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      // Stale engine columns at a band change are masked by col_cnt
      // restarting, so no flush of the engine is needed.
      if (accept) begin
        if (last_col) begin
          col_cnt  <= '0;
          band_cnt <= band_cnt + 8'd1;
        end else begin
          col_cnt <= col_cnt + 8'd1;
        end
      end
    end
  end

  // Window tracking and output register capture/handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_pend  <= 1'b0;
      tag_row   <= '0;
      tag_col   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      // A new completed window in the same cycle as a capture keeps
      // win_pend set; the capture uses the previous tags.
      if (accept && col_cnt >= 8'd6) begin
        win_pend <= 1'b1;
        tag_row  <= band_cnt;
        tag_col  <= col_cnt - 8'd6;
      end else if (capture) begin
        win_pend <= 1'b0;
      end
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= cap_data;
        out_row   <= tag_row;
        out_col   <= tag_col;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv77_ctrl.sv
// Scoreboard bench for conv77_ctrl with IMG_W=IMG_H=8 (4 outputs per frame).
// The engine is modelled as conv_value = 3*n+1, n = shifts since frame start,
// so each result's data identifies which column completed its window.
module tb_conv77_ctrl;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       in_valid;
  logic       in_ready;
  logic       conv_en;
  logic [7:0] conv_value;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_row;
  logic [7:0] out_col;

  conv77_ctrl #(.IMG_W(W), .IMG_H(H), .OUT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .conv_en(conv_en),
    .conv_value(conv_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Engine model and per-frame statistics.
  int         frame_shift;
  int         acc_cnt;
  int         done_cnt;
  int         cyc = 0;
  int         first_acc;
  int         last_acc;
  int         acc7_cyc;
  int         first_ov;
  logic       ovr;
  logic [7:0] ovr_val;

  assign conv_value = ovr ? ovr_val : 8'(frame_shift * 3 + 1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst || (start && !busy)) begin
      frame_shift <= 0;
      acc_cnt     <= 0;
      done_cnt    <= 0;
      first_acc   <= 0;
      last_acc    <= 0;
      acc7_cyc    <= 0;
      first_ov    <= 0;
    end else begin
      if (conv_en) begin
        frame_shift <= frame_shift + 1;
        acc_cnt     <= acc_cnt + 1;
        if (acc_cnt == 0) first_acc <= cyc;
        last_acc <= cyc;
        if (acc_cnt == 6) acc7_cyc <= cyc;
      end
      if (out_valid && first_ov == 0) first_ov <= cyc;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // Expected-result queue (written by stimulus, drained by the monitor).
  logic [7:0] exp_row [64];
  logic [7:0] exp_col [64];
  logic [7:0] exp_data[64];
  int wr_idx = 0;
  int rd_idx = 0;

  // Monitor: compare every handshaken result against the queue head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      tests++;
      if (rd_idx >= wr_idx) begin
        fails++;
        $display("FAIL unexpected_out: got row=%0d col=%0d data=%0h, none expected",
                 out_row, out_col, out_data);
      end else begin
        if (out_row != exp_row[rd_idx] || out_col != exp_col[rd_idx] ||
            out_data != exp_data[rd_idx]) begin
          fails++;
          $display("FAIL out[%0d]: got row=%0d col=%0d data=%0h, expected row=%0d col=%0d data=%0h",
                   rd_idx, out_row, out_col, out_data,
                   exp_row[rd_idx], exp_col[rd_idx], exp_data[rd_idx]);
        end
        rd_idx <= rd_idx + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] relu_exp(input logic [7:0] v);
`ifdef CONV77_CTRL_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  // Hand-computed results for an 8x8 frame: windows complete on shifts
  // 7, 8, 15, 16 -> 3n+1 = 22, 25, 46, 49.
  task automatic push_frame();
    logic [7:0] d [4];
    logic [7:0] r [4];
    logic [7:0] c [4];
    d = '{8'd22, 8'd25, 8'd46, 8'd49};
    r = '{8'd0, 8'd0, 8'd1, 8'd1};
    c = '{8'd0, 8'd1, 8'd0, 8'd1};
    for (int i = 0; i < 4; i++) begin
      exp_row[wr_idx]  = r[i];
      exp_col[wr_idx]  = c[i];
      exp_data[wr_idx] = ovr ? relu_exp(ovr_val) : d[i];
      wr_idx++;
    end
  endtask

  // mode 0: full rate, 1: output stall, 2: throttled input, 3: start during RUN
  task automatic run_frame(input int mode);
    bit         seen_done = 0;
    bit         bp_started = 0;
    int         hold = 0;
    logic [7:0] h_data, h_row, h_col;
    h_data = '0; h_row = '0; h_col = '0;
    @(posedge clk); #1;
    push_frame();
    start     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen_done = 1;
        break;
      end
      if (mode == 2) in_valid = ~in_valid;
      if (mode == 3) start = (k == 4);
      if (mode == 1) begin
        if (!bp_started && out_valid) begin
          bp_started = 1;
          out_ready  = 1'b0;
          h_data = out_data; h_row = out_row; h_col = out_col;
        end else if (bp_started && hold < 5) begin
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_conv_en", int'(conv_en), 0);
          chk("bp_out_valid", int'(out_valid), 1);
          chk("bp_data_stable", int'(out_data), int'(h_data));
          chk("bp_tag_stable", int'({out_row, out_col}), int'({h_row, h_col}));
          hold++;
          if (hold == 5) out_ready = 1'b1;
        end
      end
    end
    chk("done_seen", int'(seen_done), 1);
    chk("busy_at_done", int'(busy), 0);
    in_valid = 1'b0;
    start    = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("done_count", done_cnt, 1);
    chk("accept_count", acc_cnt, W * (H - 6));
    chk("outputs_consumed", rd_idx, wr_idx);
    if (mode == 0) begin
      chk("accept_span", last_acc - first_acc + 1, 16);
      chk("first_out_latency", first_ov - acc7_cyc, 2);
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovr       = 1'b0;
    ovr_val   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_tags", int'({out_row, out_col}), 0);
    rst = 1'b1;

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);

    // Reset with a window pending but not yet captured: result is dropped.
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (acc_cnt >= 7) break;
      @(posedge clk); #1;
    end
    chk("mid_accepts", acc_cnt, 7);
    chk("mid_no_out_yet", int'(out_valid), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    chk("mid_rst_tags", int'({out_row, out_col}), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_dropped", int'(out_valid), 0);
    run_frame(0);

    ovr = 1'b1;
    ovr_val = 8'hF0;
    run_frame(0);
    ovr_val = 8'h12;
    run_frame(0);
    ovr = 1'b0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
